// File: rtl/tlb.sv
// Fully-associative TLB: software fills entries in two steps (VA then PA),
// the pipeline gets a registered translation or miss/fault one cycle after lookup.

module tlb_entry #(
  parameter int ASID_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_va_we,
  input  logic                 i_pa_we,
  input  logic                 i_flush,
  input  logic [19:0]          i_fld_pn,
  input  logic [ASID_BITS-1:0] i_fld_asid,
  input  logic                 i_fld_global,
  input  logic                 i_fld_writable,
  input  logic                 i_fld_present,
  input  logic [19:0]          i_lookup_vpn,
  input  logic [ASID_BITS-1:0] i_lookup_asid,
  output logic                 o_match,
  output logic [19:0]          o_ppn,
  output logic                 o_writable
);
  typedef enum logic {S_IDLE, S_VA_LOADED} fill_state_e;

  fill_state_e          r_state, w_next;
  logic                 r_valid;
  logic [19:0]          r_vpn, r_ppn, r_pend_vpn;
  logic [ASID_BITS-1:0] r_asid, r_pend_asid;
  logic                 r_global, r_writable, r_pend_global;
  logic                 w_ld_pend, w_commit, w_inval;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (i_flush)                                  w_next = S_IDLE;
    else if (i_va_we)                             w_next = S_VA_LOADED;
    else if (i_pa_we && r_state == S_VA_LOADED)   w_next = S_IDLE;
  end

  // A VA write invalidates the live entry immediately; a PA write only
  // commits when a VA is pending, otherwise it is dropped.
  always_comb begin
    w_ld_pend = i_va_we && !i_flush;
    w_commit  = i_pa_we && !i_va_we && !i_flush && (r_state == S_VA_LOADED);
    w_inval   = i_flush || i_va_we;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)      r_valid <= 1'b0;
    else if (w_inval)  r_valid <= 1'b0;
    else if (w_commit) r_valid <= i_fld_present;

  always_ff @(posedge clk) begin
    if (w_ld_pend) begin
      r_pend_vpn    <= i_fld_pn;
      r_pend_asid   <= i_fld_asid;
      r_pend_global <= i_fld_global;
    end
    if (w_commit) begin
      r_vpn      <= r_pend_vpn;
      r_asid     <= r_pend_asid;
      r_global   <= r_pend_global;
      r_ppn      <= i_fld_pn;
      r_writable <= i_fld_writable;
    end
  end

  assign o_match    = r_valid && (r_vpn == i_lookup_vpn) &&
                      (r_global || (r_asid == i_lookup_asid));
  assign o_ppn      = r_ppn;
  assign o_writable = r_writable;
endmodule

module tlb #(
  parameter int TLB_INDEX_BITS = 3,
  parameter int ASID_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      update_va_en,
  input  logic                      update_pa_en,
  input  logic [TLB_INDEX_BITS-1:0] update_index,
  input  logic [31:0]               update_value,
  input  logic                      flush_en,
  input  logic                      lookup_en,
  input  logic [31:0]               lookup_va,
  input  logic [ASID_BITS-1:0]      lookup_asid,
  input  logic                      lookup_store,
  output logic                      tlb_valid,
  output logic                      tlb_hit,
  output logic [31:0]               tlb_pa,
  output logic                      tlb_write_fault
);
  localparam int ENTRIES = 2 ** TLB_INDEX_BITS;

  logic [ENTRIES-1:0]       w_match, w_writable;
  logic [ENTRIES-1:0][19:0] w_ppn;
  logic                     w_hit, w_wr_sel;
  logic [19:0]              w_ppn_sel;
  logic                     w_unused;

  assign w_unused = ^update_value[11:2];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    logic w_sel;
    assign w_sel = (update_index == TLB_INDEX_BITS'(g));
    tlb_entry #(.ASID_BITS(ASID_BITS)) u_ent (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_va_we       (update_va_en && w_sel),
      .i_pa_we       (update_pa_en && !update_va_en && w_sel),
      .i_flush       (flush_en),
      .i_fld_pn      (update_value[31:12]),
      .i_fld_asid    (update_value[ASID_BITS-1:0]),
      .i_fld_global  (update_value[8]),
      .i_fld_writable(update_value[1]),
      .i_fld_present (update_value[0]),
      .i_lookup_vpn  (lookup_va[31:12]),
      .i_lookup_asid (lookup_asid),
      .o_match       (w_match[g]),
      .o_ppn         (w_ppn[g]),
      .o_writable    (w_writable[g])
    );
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_ppn_sel = '0;
    w_wr_sel  = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_ppn_sel = w_ppn[i];
        w_wr_sel  = w_writable[i];
      end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tlb_valid       <= 1'b0;
      tlb_hit         <= 1'b0;
      tlb_pa          <= '0;
      tlb_write_fault <= 1'b0;
    end else begin
      tlb_valid       <= lookup_en;
      tlb_hit         <= lookup_en && w_hit;
      tlb_pa          <= (lookup_en && w_hit) ? {w_ppn_sel, lookup_va[11:0]} : '0;
      tlb_write_fault <= lookup_en && w_hit && lookup_store && !w_wr_sel;
    end

  a_va_pa_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(update_va_en && update_pa_en));
  a_single_hit: assert property (@(posedge clk) disable iff (!reset_n)
    lookup_en |-> $onehot0(w_match));
endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: lookups push expected responses, a negedge
// monitor pops and compares whenever tlb_valid is presented.

module tb_tlb;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        update_va_en = 0, update_pa_en = 0, flush_en = 0;
  logic [2:0]  update_index = '0;
  logic [31:0] update_value = '0;
  logic        lookup_en = 0, lookup_store = 0;
  logic [31:0] lookup_va = '0;
  logic [7:0]  lookup_asid = '0;
  logic        tlb_valid, tlb_hit, tlb_write_fault;
  logic [31:0] tlb_pa;

  typedef struct packed {logic hit; logic [31:0] pa; logic wf;} rsp_t;
  rsp_t exp_q[$];
  int   nvec = 0, nerr = 0;

  tlb #(.TLB_INDEX_BITS(3), .ASID_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .update_va_en(update_va_en), .update_pa_en(update_pa_en),
    .update_index(update_index), .update_value(update_value),
    .flush_en(flush_en), .lookup_en(lookup_en), .lookup_va(lookup_va),
    .lookup_asid(lookup_asid), .lookup_store(lookup_store),
    .tlb_valid(tlb_valid), .tlb_hit(tlb_hit), .tlb_pa(tlb_pa),
    .tlb_write_fault(tlb_write_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rsp_t e;
    if (reset_n) begin
      nvec++;
      if (tlb_valid) begin
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_valid: got hit=%0b pa=%h wf=%0b, no response expected",
                   tlb_hit, tlb_pa, tlb_write_fault);
        end else begin
          e = exp_q.pop_front();
          if ({tlb_hit, tlb_pa, tlb_write_fault} !== e) begin
            nerr++;
            $display("FAIL lookup_rsp @%0t: got hit=%0b pa=%h wf=%0b, want hit=%0b pa=%h wf=%0b",
                     $time, tlb_hit, tlb_pa, tlb_write_fault, e.hit, e.pa, e.wf);
          end
        end
      end else if ({tlb_hit, tlb_pa, tlb_write_fault} !== '0) begin
        nerr++;
        $display("FAIL idle_zero @%0t: got hit=%0b pa=%h wf=%0b, want all 0",
                 $time, tlb_hit, tlb_pa, tlb_write_fault);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_va(input logic [2:0] idx, input logic [31:0] v);
    update_index = idx; update_value = v; update_va_en = 1'b1;
    tick();
    update_va_en = 1'b0;
  endtask

  task automatic wr_pa(input logic [2:0] idx, input logic [31:0] v);
    update_index = idx; update_value = v; update_pa_en = 1'b1;
    tick();
    update_pa_en = 1'b0;
  endtask

  task automatic set_lk(input logic [31:0] va, input logic [7:0] asid, input logic st,
                        input logic h, input logic [31:0] pa, input logic wf);
    lookup_va = va; lookup_asid = asid; lookup_store = st; lookup_en = 1'b1;
    exp_q.push_back({h, pa, wf});
  endtask

  task automatic lk(input logic [31:0] va, input logic [7:0] asid, input logic st,
                    input logic h, input logic [31:0] pa, input logic wf);
    set_lk(va, asid, st, h, pa, wf);
    tick();
    lookup_en = 1'b0; lookup_store = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    nvec++;
    if ({tlb_valid, tlb_hit, tlb_pa, tlb_write_fault} !== '0) begin
      nerr++;
      $display("FAIL %s: got valid=%0b hit=%0b pa=%h wf=%0b, want all 0",
               nm, tlb_valid, tlb_hit, tlb_pa, tlb_write_fault);
    end
  endtask

  initial begin
    #200000;
    nerr++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("reset_state");
    reset_n = 1'b1;
    tick();

    // 1: empty TLB misses
    lk(32'h0000_1234, 8'd1, 0, 0, 32'h0, 0);

    // 2: ASID-tagged entry
    wr_va(3'd2, 32'h4000_0003);
    wr_pa(3'd2, 32'h1234_5003);
    lk(32'h4000_0ABC, 8'd3, 0, 1, 32'h1234_5ABC, 0);
    lk(32'h4000_0ABC, 8'd3, 1, 1, 32'h1234_5ABC, 0);
    lk(32'h4000_0ABC, 8'd4, 0, 0, 32'h0, 0);

    // 3: global, read-only entry
    wr_va(3'd5, 32'h5000_0100);
    wr_pa(3'd5, 32'h0007_7001);
    lk(32'h5000_0010, 8'd9, 0, 1, 32'h0007_7010, 0);
    lk(32'h5000_0010, 8'd9, 1, 1, 32'h0007_7010, 1);

    // 4: re-fill idx 2, orphan PA write, pending VA overwrite
    wr_va(3'd2, 32'h6000_0003);
    lk(32'h4000_0ABC, 8'd3, 0, 0, 32'h0, 0);
    lk(32'h6000_0ABC, 8'd3, 0, 0, 32'h0, 0);
    wr_pa(3'd2, 32'h2222_2001);
    lk(32'h6000_0ABC, 8'd3, 0, 1, 32'h2222_2ABC, 0);
    lk(32'h6000_0ABC, 8'd3, 1, 1, 32'h2222_2ABC, 1);
    lk(32'h4000_0ABC, 8'd3, 0, 0, 32'h0, 0);
    wr_va(3'd6, 32'h7000_0001);
    wr_pa(3'd6, 32'h0AAA_A003);
    wr_pa(3'd6, 32'h0BBB_B003);
    lk(32'h7000_0123, 8'd1, 0, 1, 32'h0AAA_A123, 0);
    wr_va(3'd3, 32'h8000_0001);
    wr_va(3'd3, 32'h8100_0001);
    wr_pa(3'd3, 32'h0DDD_D003);
    lk(32'h8100_0000, 8'd1, 0, 1, 32'h0DDD_D000, 0);
    lk(32'h8000_0000, 8'd1, 0, 0, 32'h0, 0);

    // 5: flush beats a simultaneous commit
    wr_va(3'd1, 32'h9000_0002);
    wr_pa(3'd1, 32'h0111_1003);
    lk(32'h9000_0456, 8'd2, 0, 1, 32'h0111_1456, 0);
    wr_va(3'd4, 32'hA000_0002);
    update_index = 3'd4; update_value = 32'h0444_4003;
    update_pa_en = 1'b1; flush_en = 1'b1;
    tick();
    update_pa_en = 1'b0; flush_en = 1'b0;
    lk(32'h9000_0456, 8'd2, 0, 0, 32'h0, 0);
    lk(32'hA000_0000, 8'd2, 0, 0, 32'h0, 0);
    lk(32'h6000_0ABC, 8'd3, 0, 0, 32'h0, 0);
    lk(32'h5000_0010, 8'd9, 0, 0, 32'h0, 0);
    lk(32'h7000_0123, 8'd1, 0, 0, 32'h0, 0);
    lk(32'h8100_0000, 8'd1, 0, 0, 32'h0, 0);
    wr_pa(3'd4, 32'h0444_4003);
    lk(32'hA000_0000, 8'd2, 0, 0, 32'h0, 0);

    // 6: lookup concurrent with commit sees old contents
    wr_va(3'd0, 32'hB000_0005);
    update_index = 3'd0; update_value = 32'h0EEE_E003; update_pa_en = 1'b1;
    set_lk(32'hB000_0123, 8'd5, 0, 0, 32'h0, 0);
    tick();
    update_pa_en = 1'b0; lookup_en = 1'b0;
    lk(32'hB000_0123, 8'd5, 0, 1, 32'h0EEE_E123, 0);

    // reset mid-fill drops the pending VA and all entries
    wr_va(3'd7, 32'hC000_0005);
    tick();
    reset_n = 1'b0;
    #1 chk_reset_outs("reset_midfill");
    tick();
    reset_n = 1'b1;
    tick();
    wr_pa(3'd7, 32'h0FFF_F003);
    lk(32'hC000_0000, 8'd5, 0, 0, 32'h0, 0);
    lk(32'hB000_0123, 8'd5, 0, 0, 32'h0, 0);

    tick();
    tick();
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
